// File: rtl/tensor_sequencer.sv
// Tensor op sequencer: loads two 9-element operands from data memory,
// triggers one MXU capture, stores 9 results, then pulses done.
// Every output comes from a flop loaded with the decode of the next state,
// so outputs change only at the clock edge.
module tensor_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       acc_mode,
  input  logic [8:0] a_base,
  input  logic [8:0] b_base,
  input  logic [8:0] r_base,
  output logic [8:0] dm_addr,
  output logic       dm_store,
  output logic       load_a,
  output logic       load_b,
  output logic       mxu_capture,
  output logic       mxu_add,
  output logic [3:0] elem_idx,
  output logic       stall,
  output logic       busy,
  output logic       done
);

  localparam int unsigned AW = 9;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LAST_ELEM = CW'(8);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LD_A = 3'd1;
  localparam logic [2:0] S_LD_B = 3'd2;
  localparam logic [2:0] S_MUL  = 3'd3;
  localparam logic [2:0] S_ST   = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc_q, acc_d;
  logic [AW-1:0] a_q, a_d, b_q, b_d, r_q, r_d;

  logic [AW-1:0] dm_addr_q, dm_addr_d;
  logic [CW-1:0] elem_idx_q, elem_idx_d;
  logic          dm_store_q, dm_store_d;
  logic          load_a_q, load_a_d;
  logic          load_b_q, load_b_d;
  logic          cap_q, cap_d;
  logic          add_q, add_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Next-state, operand latching, and decode of the upcoming cycle's outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    a_d        = a_q;
    b_d        = b_q;
    r_d        = r_q;
    dm_addr_d  = '0;
    elem_idx_d = '0;
    dm_store_d = 1'b0;
    load_a_d   = 1'b0;
    load_b_d   = 1'b0;
    cap_d      = 1'b0;
    add_d      = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LD_A;
          cnt_d   = '0;
          acc_d   = acc_mode;
          a_d     = a_base;
          b_d     = b_base;
          r_d     = r_base;
        end
      end
      S_LD_A: begin
        if (cnt_q == LAST_ELEM) begin
          cnt_d   = '0;
          state_d = S_LD_B;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LD_B: begin
        if (cnt_q == LAST_ELEM) begin
          cnt_d   = '0;
          state_d = S_MUL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_MUL: begin
        cnt_d   = '0;
        state_d = S_ST;
      end
      S_ST: begin
        if (cnt_q == LAST_ELEM) begin
          cnt_d   = '0;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    case (state_d)
      S_LD_A: begin
        busy_d     = 1'b1;
        load_a_d   = 1'b1;
        dm_addr_d  = a_d + AW'(cnt_d);
        elem_idx_d = cnt_d;
      end
      S_LD_B: begin
        busy_d     = 1'b1;
        load_b_d   = 1'b1;
        dm_addr_d  = b_d + AW'(cnt_d);
        elem_idx_d = cnt_d;
      end
      S_MUL: begin
        busy_d = 1'b1;
        cap_d  = 1'b1;
        add_d  = acc_d;
      end
      S_ST: begin
        busy_d     = 1'b1;
        dm_store_d = 1'b1;
        dm_addr_d  = r_d + AW'(cnt_d);
        elem_idx_d = cnt_d;
      end
      S_FIN: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, latched operands and output flops; reset aborts any op in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      dm_addr_q  <= '0;
      elem_idx_q <= '0;
      dm_store_q <= 1'b0;
      load_a_q   <= 1'b0;
      load_b_q   <= 1'b0;
      cap_q      <= 1'b0;
      add_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      r_q        <= r_d;
      dm_addr_q  <= dm_addr_d;
      elem_idx_q <= elem_idx_d;
      dm_store_q <= dm_store_d;
      load_a_q   <= load_a_d;
      load_b_q   <= load_b_d;
      cap_q      <= cap_d;
      add_q      <= add_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign dm_addr     = dm_addr_q;
  assign elem_idx    = elem_idx_q;
  assign dm_store    = dm_store_q;
  assign load_a      = load_a_q;
  assign load_b      = load_b_q;
  assign mxu_capture = cap_q;
  assign mxu_add     = add_q;
  assign busy        = busy_q;
  assign stall       = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_tensor_sequencer.sv
// Bench for tensor_sequencer: table of ops, expected per-cycle traces queued
// when each op is launched and popped as the DUT runs, plus reset corners.
module tb_tensor_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, acc_mode;
  logic [8:0] a_base, b_base, r_base;
  logic [8:0] dm_addr;
  logic       dm_store, load_a, load_b, mxu_capture, mxu_add;
  logic [3:0] elem_idx;
  logic       stall, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  tensor_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .acc_mode(acc_mode),
    .a_base(a_base), .b_base(b_base), .r_base(r_base),
    .dm_addr(dm_addr), .dm_store(dm_store), .load_a(load_a), .load_b(load_b),
    .mxu_capture(mxu_capture), .mxu_add(mxu_add), .elem_idx(elem_idx),
    .stall(stall), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // One cycle of observable outputs
  typedef struct packed {
    logic       la, lb, cap, add, st, done, busy, stall;
    logic [8:0] addr;
    logic [3:0] idx;
  } obs_t;

  typedef struct {
    logic       acc;
    logic [8:0] a, b, r;
    logic       chg;   // scramble inputs mid-op
    logic       hold;  // keep start high through the op
  } vec_t;

  obs_t exp_q[$];

  function automatic obs_t sample();
    obs_t o;
    o.la = load_a; o.lb = load_b; o.cap = mxu_capture; o.add = mxu_add;
    o.st = dm_store; o.done = done; o.busy = busy; o.stall = stall;
    o.addr = dm_addr; o.idx = elem_idx;
    return o;
  endfunction

  function automatic obs_t idle_obs();
    obs_t o = '0;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected 29-cycle trace of one op
  task automatic push_trace(input logic acc, input logic [8:0] a, b, r);
    obs_t o;
    for (int i = 0; i < 9; i++) begin
      o = '0; o.busy = 1; o.stall = 1; o.la = 1;
      o.addr = a + 9'(i); o.idx = 4'(i); exp_q.push_back(o);
    end
    for (int i = 0; i < 9; i++) begin
      o = '0; o.busy = 1; o.stall = 1; o.lb = 1;
      o.addr = b + 9'(i); o.idx = 4'(i); exp_q.push_back(o);
    end
    o = '0; o.busy = 1; o.stall = 1; o.cap = 1; o.add = acc; exp_q.push_back(o);
    for (int i = 0; i < 9; i++) begin
      o = '0; o.busy = 1; o.stall = 1; o.st = 1;
      o.addr = r + 9'(i); o.idx = 4'(i); exp_q.push_back(o);
    end
    o = '0; o.busy = 1; o.stall = 1; o.done = 1; exp_q.push_back(o);
  endtask

  // Launch an op and compare `ncyc` busy cycles; called #1 after a posedge
  task automatic run_op(input vec_t v, input int ncyc, input string name);
    obs_t e;
    start = 1'b1; acc_mode = v.acc; a_base = v.a; b_base = v.b; r_base = v.r;
    push_trace(v.acc, v.a, v.b, v.r);
    @(posedge clk); #1;
    if (!v.hold) start = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      if (v.chg && i == 12) begin
        acc_mode = ~v.acc;
        a_base = 9'($urandom); b_base = 9'($urandom); r_base = 9'($urandom);
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL %s: trace queue empty at cycle %0d", name, i);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s.c%0d", name, i), sample(), e);
      end
      if (i < ncyc - 1) begin @(posedge clk); #1; end
    end
  endtask

  // At most one of the four strobes on every cycle
  always @(negedge clk) begin
    n_checks++;
    if ($countones({load_a, load_b, mxu_capture, dm_store}) <= 1) n_pass++;
    else $display("FAIL excl: strobes %b expected at most one high",
                  {load_a, load_b, mxu_capture, dm_store});
  end

  vec_t vecs[6];

  initial begin
    vecs[0] = '{acc: 1'b0, a: 9'h010, b: 9'h020, r: 9'h030, chg: 1'b0, hold: 1'b0};
    vecs[1] = '{acc: 1'b0, a: 9'h1FC, b: 9'h1F9, r: 9'h1FE, chg: 1'b0, hold: 1'b0};
    vecs[2] = '{acc: 1'b1, a: 9'h040, b: 9'h080, r: 9'h100, chg: 1'b1, hold: 1'b0};
    vecs[3] = '{acc: 1'b0, a: 9'h050, b: 9'h050, r: 9'h052, chg: 1'b0, hold: 1'b0};
    vecs[4] = '{acc: 1'b1, a: 9'h0A0, b: 9'h0B0, r: 9'h0C0, chg: 1'b0, hold: 1'b1};
    vecs[5] = '{acc: 1'b0, a: 9'h1F0, b: 9'h000, r: 9'h1FF, chg: 1'b1, hold: 1'b0};

    reset = 1'b1; start = 1'b0; acc_mode = 1'b0;
    a_base = '0; b_base = '0; r_base = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", sample(), idle_obs());
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", sample(), idle_obs());

    // Table of ops; vecs[4] holds start so vecs[5] launches back to back
    for (int k = 0; k < 6; k++) begin
      run_op(vecs[k], 29, $sformatf("op%0d", k));
      @(posedge clk); #1;
      check($sformatf("op%0d.idle", k), sample(), idle_obs());
    end

    // Held start: IDLE after FIN, then re-accept on the next edge
    start = 1'b1;
    @(posedge clk); #1;
    check("hold_reaccept", sample().la, 1'b1);
    start = 1'b0;
    repeat (28) @(posedge clk);
    #1;
    check("hold_done", sample().done, 1'b1);
    @(posedge clk); #1;
    check("hold_end_idle", sample(), idle_obs());

    // Abort at ST cnt=4 with start also high: reset wins, no done, no stores
    run_op('{acc: 1'b0, a: 9'h011, b: 9'h022, r: 9'h033, chg: 1'b0, hold: 1'b0},
           24, "abort");
    exp_q.delete();
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check("abort_idle", sample(), idle_obs());
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check($sformatf("abort_quiet%0d", i), sample(), idle_obs());
    end

    // Fresh op completes normally after the abort
    run_op('{acc: 1'b1, a: 9'h1FF, b: 9'h123, r: 9'h0FA, chg: 1'b0, hold: 1'b0},
           29, "fresh");
    @(posedge clk); #1;
    check("fresh_idle", sample(), idle_obs());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tensor_sequencer.md
TENSOR_SEQUENCER -- requirements
Module: tensor_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 The ports SHALL be as follows.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request a tensor op; sampled only in IDLE
- acc_mode  in  1  0 = overwrite tensor accumulator, 1 = add into it; latched on accepted start
- a_base  in  9  DM base address of A (9 elements); latched on accepted start
- b_base  in  9  DM base address of B; latched on accepted start
- r_base  in  9  DM base address of result; latched on accepted start
- dm_addr  out  9  DM address driven this cycle
- dm_store  out  1  DM write strobe
- load_a  out  1  register file captures dm_out into A element elem_idx
- load_b  out  1  register file captures dm_out into B element elem_idx
- mxu_capture  out  1  tensor accumulator captures MXU output
- mxu_add  out  1  qualifies mxu_capture: 1 = accumulate, 0 = overwrite
- elem_idx  out  4  element index 0..8; selects the result element for the store data mux
- stall  out  1  holds the PC while the block is busy
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

Function
REQ-003 The FSM SHALL have states IDLE, LD_A, LD_B, MUL, ST, FIN, with a 4-bit element counter cnt.
REQ-004 In IDLE with start=1 the block SHALL latch the bases and acc_mode, clear cnt, and enter LD_A on the next edge.
REQ-005 In LD_A the block SHALL drive dm_addr=a_base+cnt, load_a=1 and elem_idx=cnt.
- cnt<8: cnt increments.
- cnt=8: cnt clears and the FSM enters LD_B.
REQ-006 LD_B SHALL behave identically to LD_A using b_base and load_b, and then enter MUL.
REQ-007 MUL SHALL last exactly one cycle with mxu_capture=1 and mxu_add=latched acc_mode, then enter ST.
REQ-008 In ST the block SHALL drive dm_addr=r_base+cnt, dm_store=1 and elem_idx=cnt for cnt=0..8, then enter FIN.
REQ-009 FIN SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-010 Address sums SHALL be 9-bit modulo 512 (wrap-around, no carry out); 511+1 = 0.
REQ-011 stall and busy SHALL be 1 in LD_A, LD_B, MUL, ST and FIN, and 0 in IDLE.
REQ-012 Latency SHALL be fixed: a start accepted at edge N produces done high during cycle N+29.
- The op takes 29 busy cycles: 9 LD_A, 9 LD_B, 1 MUL, 9 ST, 1 FIN.
REQ-013 start while busy SHALL be ignored, including during FIN.
- start held high through FIN is re-accepted only once the FSM is in IDLE.
REQ-014 Changes to a_base, b_base, r_base or acc_mode during an op SHALL have no effect on that op.
REQ-015 load_a, load_b, mxu_capture and dm_store SHALL be mutually exclusive; at most one is high in any cycle.
REQ-016 All outputs SHALL be registered-state decodes, glitch-free at the edge.
- In IDLE every strobe is 0, dm_addr=0 and elem_idx=0.
REQ-017 Overlapping ranges SHALL NOT be checked: if r_base overlaps a_base or b_base, the stores proceed regardless and software owns the hazard.

Reset
REQ-018 reset=1 at a rising edge SHALL force state IDLE, cnt=0 and all latched registers to 0, from any state including mid-op.
REQ-019 Outputs SHALL read 0 from the cycle after that edge.
REQ-020 An op aborted by reset SHALL NOT produce done, and no further DM writes occur.
REQ-021 reset SHALL take priority over start in the same cycle.

Verification
REQ-022 Basic op: a_base=0x010, b_base=0x020, r_base=0x030, acc_mode=0, start pulse.
- load_a at addresses 0x010..0x018, then load_b at 0x020..0x028, then one mxu_capture with mxu_add=0.
- dm_store at 0x030..0x038 with elem_idx 0..8.
- done exactly 29 cycles after acceptance; stall high for all 29 busy cycles.
REQ-023 Wrap-around: a_base=0x1FC.
- LD_A addresses are 0x1FC, 0x1FD, 0x1FE, 0x1FF, 0x000, 0x001, 0x002, 0x003, 0x004.
REQ-024 Accumulate mode: acc_mode=1, then acc_mode toggled to 0 during LD_B.
- mxu_add=1 in MUL.
- Bases changed mid-op do not alter the ST addresses.
REQ-025 Start while busy: start held high continuously.
- Ops run back to back, one IDLE cycle between FIN and the next LD_A.
- Exactly one done per op; no start is accepted during LD_A through FIN.
REQ-026 Reset mid-op: reset asserted for one cycle during ST at cnt=4.
- Next cycle: IDLE, dm_store=0, stall=0, no done.
- A fresh start afterwards completes normally with all 9 stores.
REQ-027 Exclusivity check: a checker SHALL confirm on every cycle of every test that at most one of load_a, load_b, mxu_capture and dm_store is high.
